// File: rtl/fp_pkg.sv
// Shared FPU conversion definitions: integer conv encodings and single-precision field widths.
// Used by both int_to_floating_point and floating_point_to_int.
package fp_pkg;

    typedef enum logic [1:0] {
        CONV_S32 = 2'b00,
        CONV_U32 = 2'b01,
        CONV_S64 = 2'b10,
        CONV_U64 = 2'b11
    } conv_e;

    localparam int FP32_BIAS  = 127;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int INT_W      = 64;

    // Cycles from the sampling edge to the edge that presents the result.
    localparam int ITOF_LATENCY = 3;

endpackage

// File: rtl/int_to_floating_point_if.sv
// Operand/result bundle for the integer-to-float converter; master drives operands,
// slave (the converter) returns results.
interface int_to_floating_point_if;
    import fp_pkg::*;

    logic                        in_valid;
    conv_e                       conv;
    logic [INT_W-1:0]            int_in;
    logic                        out_valid;
    logic [31:0]                 float_out;
    logic                        inexact_flag;

    modport master (
        output in_valid, conv, int_in,
        input  out_valid, float_out, inexact_flag
    );

    modport slave (
        input  in_valid, conv, int_in,
        output out_valid, float_out, inexact_flag
    );

endinterface

// File: rtl/lzc64.sv
// Combinational 64-bit leading-zero counter; returns 64 when the input is all zeros.
module lzc64 (
    input  logic [63:0] i_data,
    output logic [6:0]  o_count
);

    // Scanning upward lets the highest set bit overwrite every lower one.
    always_comb begin
        o_count = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (i_data[i]) begin
                o_count = 7'(63 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_floating_point.sv
// 32/64-bit signed/unsigned integer to IEEE-754 single conversion, round-to-nearest-even.
// Operands are registered on entry, then abs, normalize and round/pack stages follow.
module int_to_floating_point
    import fp_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    int_to_floating_point_if.slave   bus
);

    logic                   r_s0Valid;
    conv_e                  r_s0Conv;
    logic [INT_W-1:0]       r_s0Int;

    logic                   r_s1Valid;
    logic                   r_s1Sign;
    logic [INT_W-1:0]       r_s1Mag;

    logic                   r_s2Valid;
    logic                   r_s2Sign;
    logic [INT_W-1:0]       r_s2Norm;
    logic [FP32_EXP_W-1:0]  r_s2Exp;

    logic                   r_outValid;
    logic [31:0]            r_float;
    logic                   r_inexact;

    logic [INT_W-1:0]       w_operand;
    logic                   w_sign;
    logic [INT_W-1:0]       w_mag;
    logic [6:0]             w_lz;
    logic [INT_W-1:0]       w_norm;
    logic [FP32_EXP_W-1:0]  w_exp;

    logic                   w_zero;
    logic [FP32_MAN_W-1:0]  w_mant;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_roundUp;
    logic [FP32_MAN_W:0]    w_mantInc;
    logic [FP32_EXP_W-1:0]  w_expRnd;
    logic [31:0]            w_float;
    logic                   w_inexact;

    always_comb begin
        w_operand = r_s0Int;
        w_sign    = 1'b0;
        unique case (r_s0Conv)
            CONV_S32: begin
                w_operand = {{32{r_s0Int[31]}}, r_s0Int[31:0]};
                w_sign    = r_s0Int[31];
            end
            CONV_U32: w_operand = {32'b0, r_s0Int[31:0]};
            CONV_S64: w_sign    = r_s0Int[63];
            CONV_U64: w_sign    = 1'b0;
            default:  w_sign    = 1'b0;
        endcase
        // Two's-complement negate of -2^63 leaves 2^63, which is the right magnitude.
        w_mag = w_sign ? (~w_operand + 64'd1) : w_operand;
    end

    lzc64 u_lzc (
        .i_data  (r_s1Mag),
        .o_count (w_lz)
    );

    always_comb begin
        w_norm = r_s1Mag << w_lz;
        w_exp  = 8'(FP32_BIAS + 63) - {1'b0, w_lz};
    end

    always_comb begin
        w_zero    = ~r_s2Norm[63];
        w_mant    = r_s2Norm[62:40];
        w_guard   = r_s2Norm[39];
        w_sticky  = |r_s2Norm[38:0];
        w_roundUp = w_guard & (w_sticky | w_mant[0]);
        w_mantInc = {1'b0, w_mant} + {{FP32_MAN_W{1'b0}}, w_roundUp};
        // A carry out of the mantissa means it wrapped to zero: bump the exponent.
        w_expRnd  = r_s2Exp + {{(FP32_EXP_W-1){1'b0}}, w_mantInc[FP32_MAN_W]};
        w_float   = {r_s2Sign, w_expRnd, w_mantInc[FP32_MAN_W-1:0]};
        w_inexact = w_guard | w_sticky;
        if (w_zero) begin
            w_float   = 32'h0000_0000;
            w_inexact = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0Valid <= 1'b0;
            r_s0Conv  <= CONV_S32;
            r_s0Int   <= '0;
            r_s1Valid <= 1'b0;
            r_s1Sign  <= 1'b0;
            r_s1Mag   <= '0;
            r_s2Valid <= 1'b0;
            r_s2Sign  <= 1'b0;
            r_s2Norm  <= '0;
            r_s2Exp   <= '0;
        end else begin
            r_s0Valid <= bus.in_valid;
            r_s0Conv  <= bus.conv;
            r_s0Int   <= bus.int_in;
            r_s1Valid <= r_s0Valid;
            r_s1Sign  <= w_sign;
            r_s1Mag   <= w_mag;
            r_s2Valid <= r_s1Valid;
            r_s2Sign  <= r_s1Sign;
            r_s2Norm  <= w_norm;
            r_s2Exp   <= w_exp;
        end
    end

    // Result registers hold their last value across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_float    <= 32'h0000_0000;
            r_inexact  <= 1'b0;
        end else begin
            r_outValid <= r_s2Valid;
            if (r_s2Valid) begin
                r_float   <= w_float;
                r_inexact <= w_inexact;
            end
        end
    end

    assign bus.out_valid    = r_outValid;
    assign bus.float_out    = r_float;
    assign bus.inexact_flag = r_inexact;

endmodule

// File: tb/tb_int_to_floating_point.sv
// Directed self-checking bench for int_to_floating_point with hand-computed expected floats.
module tb_int_to_floating_point;
    import fp_pkg::*;

    logic clk;
    logic reset;
    int   errorCount;
    int   checkCount;

    int_to_floating_point_if bus ();

    int_to_floating_point dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        v;
        conv_e       c;
        logic [63:0] d;
        logic [31:0] f;
        logic        x;
    } vec_t;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h required %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input conv_e c, input logic [63:0] d);
        @(negedge clk);
        bus.in_valid = v;
        bus.conv     = c;
        bus.int_in   = d;
    endtask

    // One isolated operand: checks nothing appears early and the result lands after edge N+3.
    task automatic runOne(input string tag, input conv_e c, input logic [63:0] d,
                          input logic [31:0] f, input logic x);
        applyStimulus(1'b1, c, d);
        @(posedge clk);
        applyStimulus(1'b0, c, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput({tag, "_early"}, {63'b0, bus.out_valid}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, {63'b0, bus.out_valid}, 64'd1);
        checkOutput({tag, "_float"}, {32'b0, bus.float_out}, {32'b0, f});
        checkOutput({tag, "_inexact"}, {63'b0, bus.inexact_flag}, {63'b0, x});
    endtask

    vec_t        seq [6];
    logic [31:0] lastF;
    logic        lastX;

    initial begin
        errorCount = 0;
        checkCount = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.conv     = CONV_S32;
        bus.int_in   = 64'h0;

        #1;
        checkOutput("rst_valid", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("rst_float", {32'b0, bus.float_out}, 64'd0);
        checkOutput("rst_inexact", {63'b0, bus.inexact_flag}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        runOne("s32_one",     CONV_S32, 64'h0000_0000_0000_0001, 32'h3F80_0000, 1'b0);
        runOne("s32_neg1",    CONV_S32, 64'h0000_0000_FFFF_FFFF, 32'hBF80_0000, 1'b0);
        runOne("u32_max",     CONV_U32, 64'h0000_0000_FFFF_FFFF, 32'h4F80_0000, 1'b1);
        runOne("u32_tieEven", CONV_U32, 64'd16777217,            32'h4B80_0000, 1'b1);
        runOne("u32_tieUp",   CONV_U32, 64'd16777219,            32'h4B80_0002, 1'b1);
        runOne("u32_exact",   CONV_U32, 64'd16777218,            32'h4B80_0001, 1'b0);
        runOne("u32_sticky",  CONV_U32, 64'd33554433,            32'h4C00_0000, 1'b1);
        runOne("s64_m1917",   CONV_S64, 64'hFFFF_FFFF_FFFF_F883, 32'hC4EF_A000, 1'b0);
        runOne("s64_min",     CONV_S64, 64'h8000_0000_0000_0000, 32'hDF00_0000, 1'b0);
        runOne("s64_max",     CONV_S64, 64'h7FFF_FFFF_FFFF_FFFF, 32'h5F00_0000, 1'b1);
        runOne("u64_max",     CONV_U64, 64'hFFFF_FFFF_FFFF_FFFF, 32'h5F80_0000, 1'b1);
        runOne("s32_upperIg", CONV_S32, 64'hDEAD_BEEF_0000_0005, 32'h40A0_0000, 1'b0);
        runOne("s32_min",     CONV_S32, 64'h0000_0000_8000_0000, 32'hCF00_0000, 1'b0);
        runOne("u32_zero",    CONV_U32, 64'hFFFF_FFFF_0000_0000, 32'h0000_0000, 1'b0);

        // Back-to-back stream with a bubble, then zero.
        seq[0] = '{1'b1, CONV_S32, 64'd1,                    32'h3F80_0000, 1'b0};
        seq[1] = '{1'b1, CONV_U32, 64'd16777219,             32'h4B80_0002, 1'b1};
        seq[2] = '{1'b1, CONV_S64, 64'hFFFF_FFFF_FFFF_F883,  32'hC4EF_A000, 1'b0};
        seq[3] = '{1'b1, CONV_U64, 64'hFFFF_FFFF_FFFF_FFFF,  32'h5F80_0000, 1'b1};
        seq[4] = '{1'b0, CONV_S32, 64'd7,                    32'h0,         1'b0};
        seq[5] = '{1'b1, CONV_S32, 64'd0,                    32'h0000_0000, 1'b0};
        lastF = 32'h0000_0000;
        lastX = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 6) applyStimulus(seq[k].v, seq[k].c, seq[k].d);
            else       applyStimulus(1'b0, CONV_S32, 64'h0);
            @(posedge clk);
            #1;
            if (k >= 3) begin
                checkOutput($sformatf("stream%0d_valid", k - 3), {63'b0, bus.out_valid}, {63'b0, seq[k-3].v});
                if (seq[k-3].v) begin
                    lastF = seq[k-3].f;
                    lastX = seq[k-3].x;
                end
                checkOutput($sformatf("stream%0d_float", k - 3), {32'b0, bus.float_out}, {32'b0, lastF});
                checkOutput($sformatf("stream%0d_inexact", k - 3), {63'b0, bus.inexact_flag}, {63'b0, lastX});
            end
        end

        // Reset with operands in flight and a valid result on the output.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, CONV_S64, 64'h7FFF_FFFF_FFFF_FFFF);
            @(posedge clk);
        end
        #1;
        checkOutput("preRst_valid", {63'b0, bus.out_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRst_valid", {63'b0, bus.out_valid}, 64'd0);
        checkOutput("midRst_float", {32'b0, bus.float_out}, 64'd0);
        applyStimulus(1'b0, CONV_S32, 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("postRst%0d_valid", k), {63'b0, bus.out_valid}, 64'd0);
        end
        runOne("postRst_op", CONV_S32, 64'h0000_0000_FFFF_FFFF, 32'hBF80_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
